// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Brief    : Instruction fetch front end: sequential PC generation, SRAM-like
//            request port, in-order return FIFO with valid/ready to ID.
//            FETCH_ADEF_EN enables misaligned-PC (ADEF) exception entries.
// Revision : 1.0
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h1c000000,
    parameter int          IBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_adef,
    input  logic        id_ready
);

    localparam int                c_PTR_W   = $clog2(IBUF_DEPTH);
    localparam int                c_CW      = c_PTR_W + 1;
    localparam logic [c_CW:0]     c_DEPTH   = (c_CW + 1)'(IBUF_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CW-1:0]   c_CNT_ONE = c_CW'(1);

    logic [31:0]        r_pc;
    logic               r_started;
    logic               r_adef_stall;
    logic [c_CW-1:0]    r_inflight;
    logic [c_CW-1:0]    r_discard;
    logic [c_CW-1:0]    r_count;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_pq_rd;
    logic [c_PTR_W-1:0] r_pq_wr;
    logic [31:0]        r_buf_inst [IBUF_DEPTH];
    logic [31:0]        r_buf_pc   [IBUF_DEPTH];
    logic [31:0]        r_pq       [IBUF_DEPTH];

    logic               w_misaligned;
    logic [31:0]        w_addr;
    logic               w_adef_push;
    logic [31:0]        w_push_inst;
    logic [31:0]        w_push_pc;
    logic [c_CW:0]      w_occ;
    logic               w_req;
    logic               w_acc;
    logic               w_drop;
    logic               w_keep;
    logic               w_push;
    logic               w_pop;
    logic               w_if_valid;
    logic [c_CW-1:0]    w_inflight_nxt;

`ifdef FETCH_ADEF_EN
    localparam logic [31:0]     c_NOP  = 32'h03400000;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(IBUF_DEPTH);

    logic r_buf_adef [IBUF_DEPTH];

    // ADEF entry only once the old stream has fully drained
    assign w_misaligned = |r_pc[1:0];
    assign w_addr       = r_pc;
    assign w_adef_push  = r_started & w_misaligned & ~r_adef_stall
                        & (r_inflight == '0) & (r_discard == '0)
                        & (r_count != c_FULL) & ~redirect_valid;
    assign w_push_inst  = w_adef_push ? c_NOP : inst_sram_rdata;
    assign w_push_pc    = w_adef_push ? r_pc  : r_pq[r_pq_rd];
    assign if_adef      = w_if_valid & r_buf_adef[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) r_buf_adef[r_wr_ptr] <= w_adef_push;
    end
`else
    assign w_misaligned = 1'b0;
    assign w_addr       = {r_pc[31:2], 2'b00};
    assign w_adef_push  = 1'b0;
    assign w_push_inst  = inst_sram_rdata;
    assign w_push_pc    = r_pq[r_pq_rd];
    assign if_adef      = 1'b0;
`endif

    // Credit counts stale requests too, so the FIFO can never overflow
    assign w_occ          = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_req          = resetn & r_started & ~r_adef_stall & ~w_misaligned
                          & (w_occ < c_DEPTH) & ~redirect_valid;
    assign w_acc          = w_req & inst_sram_addr_ok;
    assign w_drop         = inst_sram_data_ok & (r_discard != '0);
    assign w_keep         = inst_sram_data_ok & ~w_drop;
    assign w_push         = w_keep | w_adef_push;
    assign w_if_valid     = (r_count != '0);
    assign w_pop          = w_if_valid & id_ready;
    assign w_inflight_nxt = r_inflight + c_CW'(w_acc) - c_CW'(inst_sram_data_ok);

    assign inst_sram_req  = w_req;
    assign inst_sram_addr = w_addr;
    assign if_valid       = w_if_valid;
    assign if_inst        = w_if_valid ? r_buf_inst[r_rd_ptr] : 32'h0;
    assign if_pc          = w_if_valid ? r_buf_pc[r_rd_ptr]   : 32'h0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pc         <= RESET_PC;
            r_started    <= 1'b0;
            r_adef_stall <= 1'b0;
            r_inflight   <= '0;
            r_discard    <= '0;
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_pq_rd      <= '0;
            r_pq_wr      <= '0;
        end else begin
            r_started  <= 1'b1;
            r_inflight <= w_inflight_nxt;
            if (redirect_valid) begin
                // everything still outstanding after this edge is old-stream
                r_pc         <= redirect_pc;
                r_adef_stall <= 1'b0;
                r_discard    <= w_inflight_nxt;
                r_count      <= '0;
                r_rd_ptr     <= '0;
                r_wr_ptr     <= '0;
                r_pq_rd      <= '0;
                r_pq_wr      <= '0;
            end else begin
                if (w_acc) begin
                    r_pc    <= r_pc + 32'd4;
                    r_pq_wr <= r_pq_wr + c_PTR_ONE;
                end
                if (w_drop)      r_discard    <= r_discard - c_CNT_ONE;
                if (w_keep)      r_pq_rd      <= r_pq_rd + c_PTR_ONE;
                if (w_adef_push) r_adef_stall <= 1'b1;
                if (w_push)      r_wr_ptr     <= r_wr_ptr + c_PTR_ONE;
                if (w_pop)       r_rd_ptr     <= r_rd_ptr + c_PTR_ONE;
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            end
        end
    end

    // Storage arrays need no reset: occupancy and pointers qualify them
    always_ff @(posedge clk) begin
        if (w_acc) r_pq[r_pq_wr] <= r_pc;
        if (w_push) begin
            r_buf_inst[r_wr_ptr] <= w_push_inst;
            r_buf_pc[r_wr_ptr]   <= w_push_pc;
        end
    end

endmodule
`default_nettype wire
